// File: rtl/alu_control_mc.sv
// alu_control_mc: registered ALU/MDU decode with multi-cycle MUL/DIV sequencing and stall
module alu_control_mc #(
   parameter int ALU_OP_WIDTH = 3,
   parameter int OP_WIDTH     = 5,
   parameter int MUL_CYCLES   = 4,
   parameter int DIV_CYCLES   = 33,
   parameter int CNT_WIDTH    = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    valid_i,
   input  logic                    flush_i,
   input  logic [6:0]              funct7_i,
   input  logic [ALU_OP_WIDTH-1:0] ALU_Op_i,
   input  logic [2:0]              funct3_i,
   input  logic                    div_zero_i,
   output logic [OP_WIDTH-1:0]     ALU_Operation_o,
   output logic                    alu_valid_o,
   output logic                    mdu_start_o,
   output logic                    mdu_done_o,
   output logic                    stall_o,
   output logic                    illegal_o
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
   state_e               state_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [OP_WIDTH-1:0]  op_q;
   logic                 alu_valid_q, mdu_start_q, mdu_done_q, illegal_q;
   logic [4:0]           base_d, op_d;
   logic                 ill_d, capture;
   // funct3 table shared by R (funct7=0) and the plain I-type immediates
   always_comb begin
      case (funct3_i)
         3'b000:  base_d = 5'b00000;
         3'b001:  base_d = 5'b00101;
         3'b010:  base_d = 5'b01010;
         3'b011:  base_d = 5'b01011;
         3'b100:  base_d = 5'b00010;
         3'b101:  base_d = 5'b00111;
         3'b110:  base_d = 5'b00011;
         default: base_d = 5'b00100;
      endcase
   end
   // full decode; illegal encodings fall back to ADD so EX can trap cleanly
   always_comb begin
      op_d  = 5'b00000;
      ill_d = 1'b0;
      case (ALU_Op_i)
         ALU_OP_WIDTH'(0): begin
            if (funct7_i == 7'b0000000) op_d = base_d;
            else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) op_d = 5'b00001;
            else if (funct7_i == 7'b0100000 && funct3_i == 3'b101) op_d = 5'b00110;
            else if (funct7_i == 7'b0000001) op_d = {2'b10, funct3_i};
            else ill_d = 1'b1;
         end
         ALU_OP_WIDTH'(1): begin
            if (funct3_i == 3'b001) begin
               if (funct7_i == 7'b0000000) op_d = 5'b00101;
               else ill_d = 1'b1;
            end else if (funct3_i == 3'b101) begin
               if (funct7_i == 7'b0000000) op_d = 5'b00111;
               else if (funct7_i == 7'b0100000) op_d = 5'b00110;
               else ill_d = 1'b1;
            end else op_d = base_d;
         end
         ALU_OP_WIDTH'(2): op_d = 5'b01001;
         ALU_OP_WIDTH'(3): op_d = 5'b01100;
         ALU_OP_WIDTH'(4): op_d = 5'b01101;
         default:          ill_d = 1'b1;
      endcase
   end
   assign capture = state_q == IDLE && valid_i && !flush_i;
   assign stall_o = state_q == MUL || state_q == DIV || (capture && op_d[4]);
   // sequencer: captures in IDLE, counts MDU latency, emits one-cycle start/done/valid pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         alu_valid_q <= 1'b0;
         mdu_start_q <= 1'b0;
         mdu_done_q  <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         alu_valid_q <= 1'b0;
         mdu_start_q <= 1'b0;
         mdu_done_q  <= 1'b0;
         illegal_q   <= 1'b0;
         if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: if (valid_i) begin
                  op_q <= OP_WIDTH'(op_d);
                  if (!op_d[4]) begin
                     alu_valid_q <= 1'b1;
                     illegal_q   <= ill_d;
                  end else begin
                     mdu_start_q <= 1'b1;
                     if (op_d[2]) begin
                        cnt_q <= CNT_WIDTH'(DIV_CYCLES - 2);
                        if (div_zero_i) begin
                           state_q    <= DONE;
                           mdu_done_q <= 1'b1;
                        end else state_q <= DIV;
                     end else begin
                        cnt_q   <= CNT_WIDTH'(MUL_CYCLES - 2);
                        state_q <= MUL;
                     end
                  end
               end
               MUL, DIV: if (cnt_q == '0) begin
                  state_q    <= DONE;
                  mdu_done_q <= 1'b1;
               end else cnt_q <= cnt_q - 1'b1;
               DONE: state_q <= IDLE;
            endcase
         end
      end
   end
   assign ALU_Operation_o = op_q;
   assign alu_valid_o     = alu_valid_q;
   assign mdu_start_o     = mdu_start_q;
   assign mdu_done_o      = mdu_done_q;
   assign illegal_o       = illegal_q;
endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: vector table, MDU corner sequences and random run against a cycle-count model
module tb_alu_control_mc;
   localparam int MULC = 4;
   localparam int DIVC = 33;
   logic       clk = 1'b0, reset, valid_i, flush_i, div_zero_i;
   logic [6:0] funct7_i;
   logic [2:0] ALU_Op_i, funct3_i;
   logic [4:0] ALU_Operation_o;
   logic       alu_valid_o, mdu_start_o, mdu_done_o, stall_o, illegal_o;
   int         n_cmp = 0, n_bad = 0, cur = 0, busy_end = -1;
   logic [4:0] m_op = 5'b0;
   logic       m_av = 1'b0, m_ill = 1'b0, m_start = 1'b0;
   bit         ok = 1'b0;
   typedef struct {logic [6:0] f7; logic [2:0] aop; logic [2:0] f3; logic [4:0] code; logic ill;} vec_t;
   vec_t tbl[14];

   alu_control_mc dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i), .funct7_i(funct7_i),
      .ALU_Op_i(ALU_Op_i), .funct3_i(funct3_i), .div_zero_i(div_zero_i),
      .ALU_Operation_o(ALU_Operation_o), .alu_valid_o(alu_valid_o), .mdu_start_o(mdu_start_o),
      .mdu_done_o(mdu_done_o), .stall_o(stall_o), .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cur);
      end
   endtask

   // decode written straight from the instruction-class rules
   function automatic void ref_decode(input logic [6:0] f7, input logic [2:0] aop, input logic [2:0] f3,
                                      output logic [4:0] c, output logic il);
      logic [4:0] base [8];
      base = '{5'd0, 5'd5, 5'd10, 5'd11, 5'd2, 5'd7, 5'd3, 5'd4};
      c = 5'd0;
      il = 1'b0;
      case (aop)
         3'd0: if (f7 == 7'h00) c = base[f3];
               else if (f7 == 7'h20 && f3 == 3'd0) c = 5'd1;
               else if (f7 == 7'h20 && f3 == 3'd5) c = 5'd6;
               else if (f7 == 7'h01) c = 5'd16 + 5'(f3);
               else il = 1'b1;
         3'd1: if (f3 == 3'd1) il = f7 != 7'h00;
               else if (f3 == 3'd5) begin
                  if (f7 == 7'h00) c = 5'd7;
                  else if (f7 == 7'h20) c = 5'd6;
                  else il = 1'b1;
               end else c = base[f3];
         3'd2: c = 5'd9;
         3'd3: c = 5'd12;
         3'd4: c = 5'd13;
         default: il = 1'b1;
      endcase
      if (aop == 3'd1 && f3 == 3'd1 && !il) c = 5'd5;
      if (il) c = 5'd0;
   endfunction

   // one clock: drive, check current cycle against the model, advance model, clock
   task automatic tick(input bit r, input bit v, input bit f, input logic [6:0] f7,
                       input logic [2:0] aop, input logic [2:0] f3, input bit dz);
      logic [4:0] c;
      logic       il, mdu, busy;
      reset = r; valid_i = v; flush_i = f; funct7_i = f7; ALU_Op_i = aop; funct3_i = f3; div_zero_i = dz;
      #1;
      busy = busy_end >= 0 && cur <= busy_end;
      ref_decode(f7, aop, f3, c, il);
      mdu = c >= 5'd16;
      if (ok) begin
         chk("m_op", ALU_Operation_o, m_op);
         chk("m_alu_valid", alu_valid_o, m_av);
         chk("m_illegal", illegal_o, m_ill);
         chk("m_start", mdu_start_o, m_start);
         chk("m_done", mdu_done_o, cur == busy_end);
         chk("m_stall", stall_o, (busy && cur < busy_end) || (!busy && v && !f && mdu));
      end
      m_av = 1'b0; m_ill = 1'b0; m_start = 1'b0;
      if (r) begin
         ok = 1'b1; busy_end = -1; m_op = 5'd0;
      end else if (f) busy_end = -1;
      else if (!busy && v) begin
         m_op = c;
         if (mdu) begin
            m_start = 1'b1;
            busy_end = cur + (c[2] ? (dz ? 1 : DIVC) : MULC);
         end else begin
            m_av = 1'b1; m_ill = il;
         end
      end
      @(posedge clk);
      cur++;
      #1;
   endtask

   task automatic idle();
      tick(0, 0, 0, 7'h00, 3'd0, 3'd0, 0);
   endtask

   initial begin
      int st, k, dn;
      tbl[0]  = '{7'h00, 3'd0, 3'd0, 5'b00000, 1'b0};
      tbl[1]  = '{7'h20, 3'd0, 3'd0, 5'b00001, 1'b0};
      tbl[2]  = '{7'h20, 3'd0, 3'd5, 5'b00110, 1'b0};
      tbl[3]  = '{7'h00, 3'd0, 3'd3, 5'b01011, 1'b0};
      tbl[4]  = '{7'h02, 3'd0, 3'd0, 5'b00000, 1'b1};
      tbl[5]  = '{7'h00, 3'd7, 3'd0, 5'b00000, 1'b1};
      tbl[6]  = '{7'h20, 3'd1, 3'd1, 5'b00000, 1'b1};
      tbl[7]  = '{7'h20, 3'd1, 3'd5, 5'b00110, 1'b0};
      tbl[8]  = '{7'h7f, 3'd1, 3'd2, 5'b01010, 1'b0};
      tbl[9]  = '{7'h33, 3'd2, 3'd4, 5'b01001, 1'b0};
      tbl[10] = '{7'h01, 3'd3, 3'd2, 5'b01100, 1'b0};
      tbl[11] = '{7'h01, 3'd4, 3'd2, 5'b01101, 1'b0};
      tbl[12] = '{7'h00, 3'd5, 3'd0, 5'b00000, 1'b1};
      tbl[13] = '{7'h20, 3'd0, 3'd7, 5'b00000, 1'b1};
      tick(1, 0, 0, 7'h00, 3'd0, 3'd0, 0);
      tick(1, 0, 0, 7'h00, 3'd0, 3'd0, 0);
      chk("rst_op", ALU_Operation_o, 0);
      chk("rst_valid", alu_valid_o, 0);
      chk("rst_stall", stall_o, 0);
      idle();
      foreach (tbl[i]) begin
         tick(0, 1, 0, tbl[i].f7, tbl[i].aop, tbl[i].f3, 0);
         chk("tbl_code", ALU_Operation_o, tbl[i].code);
         chk("tbl_illegal", illegal_o, tbl[i].ill);
         chk("tbl_alu_valid", alu_valid_o, 1);
         chk("tbl_stall", stall_o, 0);
         idle();
         chk("tbl_valid_drop", alu_valid_o, 0);
      end
      tick(0, 1, 0, 7'h01, 3'd0, 3'd0, 0);
      chk("mul_start", mdu_start_o, 1);
      chk("mul_code", ALU_Operation_o, 5'b10000);
      st = 0; k = 1;
      while (!mdu_done_o && k < 50) begin
         if (stall_o) st++;
         idle();
         k++;
      end
      chk("mul_stall_cycles", st, 3);
      chk("mul_done_cycle", k, 4);
      chk("mul_done_stall", stall_o, 0);
      chk("mul_done_code", ALU_Operation_o, 5'b10000);
      idle();
      tick(0, 1, 0, 7'h01, 3'd0, 3'd5, 1);
      chk("divz_start", mdu_start_o, 1);
      chk("divz_done", mdu_done_o, 1);
      chk("divz_stall", stall_o, 0);
      chk("divz_code", ALU_Operation_o, 5'b10101);
      idle();
      chk("divz_done_drop", mdu_done_o, 0);
      tick(0, 1, 0, 7'h01, 3'd0, 3'd4, 0);
      repeat (4) idle();
      chk("div_stall_mid", stall_o, 1);
      tick(0, 0, 1, 7'h00, 3'd0, 3'd0, 0);
      chk("flush_done", mdu_done_o, 0);
      chk("flush_stall", stall_o, 0);
      dn = 0;
      repeat (40) begin
         idle();
         dn += int'(mdu_done_o);
      end
      chk("flush_no_done", dn, 0);
      tick(0, 1, 0, 7'h01, 3'd0, 3'd6, 0);
      repeat (5) idle();
      tick(1, 0, 0, 7'h00, 3'd0, 3'd0, 0);
      chk("rst_mid_op", ALU_Operation_o, 0);
      chk("rst_mid_stall", stall_o, 0);
      chk("rst_mid_done", mdu_done_o, 0);
      chk("rst_mid_start", mdu_start_o, 0);
      tick(0, 1, 0, 7'h55, 3'd1, 3'd0, 0);
      chk("addi_after_rst_valid", alu_valid_o, 1);
      chk("addi_after_rst_code", ALU_Operation_o, 0);
      chk("addi_after_rst_ill", illegal_o, 0);
      for (int i = 0; i < 1500; i++) begin
         logic [6:0] f7;
         case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         tick($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
              f7, 3'($urandom_range(0, 7)), 3'($urandom), $urandom_range(0, 3) == 0);
      end
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
